lfsr_axis_src: RTL and testbench

Pseudo-random stimulus source for the histogram datapath. It is a 32-bit Galois LFSR with a seed/start/stop control interface and an AXI-Stream master output. The output feeds the histogram stage's `s_axis_*` slave port, which bins the low byte of each word. The block generates either a programmed number of samples or a continuous stream, and holds the output stable under backpressure.

---
 rtl/lfsr_pkg.sv | 15 +
 rtl/lfsr_step.sv | 14 +
 rtl/lfsr_axis_src.sv | 123 ++++++++++++
 tb/tb_lfsr_axis_src.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR stimulus source: FSM state encoding and
// the default polynomial/seed used by the RTL and by reference models.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } lfsr_state_e;

    // x^32 + x^22 + x^2 + x + 1, right-shift Galois form
    localparam logic [31:0] LFSR_DEFAULT_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

endpackage

// File: rtl/lfsr_step.sv
// One right-shift Galois LFSR step, purely combinational so the same
// next-state function can be reused wherever the sequence must be predicted.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter logic [31:0] TAPS = LFSR_DEFAULT_TAPS
) (
    input  logic [31:0] cur,
    output logic [31:0] nxt
);

    assign nxt = (cur >> 1) ^ (cur[0] ? TAPS : 32'h0);

endmodule

// File: rtl/lfsr_axis_src.sv
// Pseudo-random AXI-Stream source: 32-bit Galois LFSR with seed/start/stop control.
// Define LFSR_AXIS_TLAST_EN to add m_axis_tlast marking the final beat of a run.
module lfsr_axis_src
    import lfsr_pkg::*;
#(
    parameter logic [31:0] TAPS         = LFSR_DEFAULT_TAPS,
    parameter logic [31:0] DEFAULT_SEED = LFSR_DEFAULT_SEED,
    parameter int          CNT_W        = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [31:0]      seed,
    input  logic             load_seed,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
`ifdef LFSR_AXIS_TLAST_EN
    ,
    output logic             m_axis_tlast
`endif
);

    lfsr_state_e      state;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cnt_inc;
    logic             stop_pend;
    logic             handshake;
    logic             hit_target;
    logic             run_end;

    lfsr_step #(.TAPS(TAPS)) u_step (
        .cur (lfsr),
        .nxt (lfsr_next)
    );

    assign m_axis_tdata = lfsr;
    assign cnt_inc      = count + CNT_W'(1);
    assign handshake    = (state == RUN) && m_axis_tvalid && m_axis_tready;
    assign hit_target   = (target != '0) && (cnt_inc == target);
    // A stop arriving on the handshake cycle ends the run with that beat.
    assign run_end      = hit_target || stop_pend || stop;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            lfsr          <= DEFAULT_SEED;
            count         <= '0;
            target        <= '0;
            stop_pend     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Seed loads in the same edge as start, so the first beat carries it.
                    if (load_seed) begin
                        lfsr <= (seed == '0) ? DEFAULT_SEED : seed;
                    end
                    if (start) begin
                        target        <= num_samples;
                        count         <= '0;
                        state         <= RUN;
                        busy          <= 1'b1;
                        m_axis_tvalid <= 1'b1;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        lfsr  <= lfsr_next;
                        count <= cnt_inc;
                        if (run_end) begin
                            state         <= FINISH;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            m_axis_tvalid <= 1'b0;
                        end
                    end else if (stop) begin
                        // tvalid may not drop until the outstanding beat is taken.
                        stop_pend <= 1'b1;
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    stop_pend <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LFSR_AXIS_TLAST_EN
    logic [CNT_W-1:0] cnt_inc2;

    assign cnt_inc2 = count + CNT_W'(2);

    // tlast describes the beat currently presented, so it only moves when a
    // new beat is presented or a stop makes the current beat the last one.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tlast <= 1'b0;
        end else if ((state == IDLE) && start) begin
            m_axis_tlast <= (num_samples == CNT_W'(1));
        end else if (handshake) begin
            m_axis_tlast <= !run_end && (target != '0) && (cnt_inc2 == target);
        end else if ((state == RUN) && stop) begin
            m_axis_tlast <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_axis_src.sv
// Directed self-checking bench for lfsr_axis_src: fixed runs, backpressure,
// seed handling, continuous run with stop, and asynchronous reset.
module tb_lfsr_axis_src;

    localparam int CNT_W = 16;
    localparam logic [31:0] SEQ1 [4] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [31:0]      seed = '0;
    logic             load_seed = 1'b0;
    logic [CNT_W-1:0] num_samples = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             busy;
    logic             done;
    logic [31:0]      m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b0;
    logic             tlast_w;

    lfsr_axis_src dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .seed          (seed),
        .load_seed     (load_seed),
        .num_samples   (num_samples),
        .start         (start),
        .stop          (stop),
        .busy          (busy),
        .done          (done),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef LFSR_AXIS_TLAST_EN
        ,
        .m_axis_tlast  (tlast_w)
`endif
    );

`ifndef LFSR_AXIS_TLAST_EN
    assign tlast_w = 1'b0;
`endif

    always #5 aclk = ~aclk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] got_q [$];
    logic        last_q [$];
    int          busy_cnt;
    int          done_cnt;

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_capture();
        got_q.delete();
        last_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    // Runs ncyc cycles, recording accepted beats and checking stall stability.
    task automatic capture(input int ncyc, input bit toggle);
        logic        prev_stall;
        logic [31:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < ncyc; i++) begin
            m_axis_tready = toggle ? (i % 2 == 0) : 1'b1;
            if (prev_stall) begin
                n_vec++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data) begin
                    $display("FAIL stall_hold: tvalid=%b tdata=%h, required tvalid=1 tdata=%h",
                             m_axis_tvalid, m_axis_tdata, prev_data);
                    n_err++;
                end
            end
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back(m_axis_tdata);
                last_q.push_back(tlast_w);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            tick();
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec += 4;
        if (m_axis_tvalid !== 1'b0) begin $display("FAIL reset_tvalid: got %b required 0", m_axis_tvalid); n_err++; end
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b required 0", busy); n_err++; end
        if (done !== 1'b0) begin $display("FAIL reset_done: got %b required 0", done); n_err++; end
        if (m_axis_tdata !== 32'h1) begin $display("FAIL reset_tdata: got %h required 00000001", m_axis_tdata); n_err++; end
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        seed = 32'h1; load_seed = 1'b1; start = 1'b1; num_samples = 16'd4; m_axis_tready = 1'b1;
        tick();
        load_seed = 1'b0; start = 1'b0;
        clear_capture();
        capture(8, 1'b0);
        n_vec += 3;
        if (got_q.size() != 4) begin $display("FAIL basic_beats: got %0d required 4", got_q.size()); n_err++; end
        if (busy_cnt != 4) begin $display("FAIL basic_busy_cycles: got %0d required 4", busy_cnt); n_err++; end
        if (done_cnt != 1) begin $display("FAIL basic_done_pulses: got %0d required 1", done_cnt); n_err++; end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== SEQ1[i]) begin $display("FAIL basic_tdata[%0d]: got %h required %h", i, got_q[i], SEQ1[i]); n_err++; end
`ifdef LFSR_AXIS_TLAST_EN
            n_vec++;
            if (last_q[i] !== (i == 3)) begin $display("FAIL basic_tlast[%0d]: got %b required %b", i, last_q[i], i == 3); n_err++; end
`endif
        end
    endtask

    task automatic test_backpressure();
        seed = 32'h1; load_seed = 1'b1; start = 1'b1; num_samples = 16'd4;
        tick();
        load_seed = 1'b0; start = 1'b0;
        clear_capture();
        capture(14, 1'b1);
        n_vec += 2;
        if (got_q.size() != 4) begin $display("FAIL bp_beats: got %0d required 4", got_q.size()); n_err++; end
        if (done_cnt != 1) begin $display("FAIL bp_done_pulses: got %0d required 1", done_cnt); n_err++; end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== SEQ1[i]) begin $display("FAIL bp_tdata[%0d]: got %h required %h", i, got_q[i], SEQ1[i]); n_err++; end
        end
    endtask

    task automatic test_zero_seed();
        logic [31:0] exp3 [3];
        exp3 = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002};
        seed = 32'h0; load_seed = 1'b1;
        tick();
        load_seed = 1'b0;
        n_vec++;
        if (m_axis_tdata !== 32'h1) begin $display("FAIL zero_seed_load: got %h required 00000001", m_axis_tdata); n_err++; end
        num_samples = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        clear_capture();
        seed = 32'hDEAD_BEEF; load_seed = 1'b1;
        capture(2, 1'b0);
        load_seed = 1'b0;
        capture(6, 1'b0);
        n_vec += 2;
        if (got_q.size() != 3) begin $display("FAIL run_load_beats: got %0d required 3", got_q.size()); n_err++; end
        if (done_cnt != 1) begin $display("FAIL run_load_done: got %0d required 1", done_cnt); n_err++; end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp3[i]) begin $display("FAIL run_load_tdata[%0d]: got %h required %h", i, got_q[i], exp3[i]); n_err++; end
        end
    endtask

    task automatic test_load_and_start();
        seed = 32'h1234_5678; load_seed = 1'b1; start = 1'b1; num_samples = 16'd2;
        tick();
        load_seed = 1'b0; start = 1'b0;
        clear_capture();
        capture(6, 1'b0);
        n_vec += 2;
        if (got_q.size() != 2) begin $display("FAIL ls_beats: got %0d required 2", got_q.size()); n_err++; end
        if (done_cnt != 1) begin $display("FAIL ls_done: got %0d required 1", done_cnt); n_err++; end
        if (got_q.size() == 2) begin
            n_vec += 2;
            if (got_q[0] !== 32'h1234_5678) begin $display("FAIL ls_tdata0: got %h required 12345678", got_q[0]); n_err++; end
            if (got_q[1] !== 32'h091A_2B3C) begin $display("FAIL ls_tdata1: got %h required 091a2b3c", got_q[1]); n_err++; end
        end
    endtask

    task automatic test_continuous_stop();
        logic [31:0] model;
        int          bad;
        int          n_last;
        seed = 32'h1; load_seed = 1'b1; start = 1'b1; num_samples = 16'd0;
        tick();
        load_seed = 1'b0; start = 1'b0;
        clear_capture();
        capture(300, 1'b0);
        model = 32'h1;
        for (int i = 0; i < 300; i++) model = ref_step(model);
        m_axis_tready = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        n_vec += 2;
        if (m_axis_tvalid !== 1'b1) begin $display("FAIL stop_tvalid_held: got %b required 1", m_axis_tvalid); n_err++; end
        if (busy !== 1'b1) begin $display("FAIL stop_busy_held: got %b required 1", busy); n_err++; end
        tick();
        n_vec += 2;
        if (m_axis_tvalid !== 1'b1) begin $display("FAIL stop_tvalid_stall: got %b required 1", m_axis_tvalid); n_err++; end
        if (m_axis_tdata !== model) begin $display("FAIL stop_tdata_stall: got %h required %h", m_axis_tdata, model); n_err++; end
`ifdef LFSR_AXIS_TLAST_EN
        n_vec++;
        if (tlast_w !== 1'b1) begin $display("FAIL stop_tlast_pending: got %b required 1", tlast_w); n_err++; end
`endif
        capture(6, 1'b0);
        n_vec += 2;
        if (got_q.size() != 301) begin $display("FAIL cont_beats: got %0d required 301", got_q.size()); n_err++; end
        if (done_cnt != 1) begin $display("FAIL cont_done: got %0d required 1", done_cnt); n_err++; end
        model  = 32'h1;
        bad    = 0;
        n_last = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] !== model) bad++;
            if (last_q[i] === 1'b1 && i != 300) n_last++;
            model = ref_step(model);
        end
        n_vec++;
        if (bad != 0) begin $display("FAIL cont_tdata: %0d beats differ, required 0", bad); n_err++; end
`ifdef LFSR_AXIS_TLAST_EN
        n_vec += 2;
        if (n_last != 0) begin $display("FAIL cont_tlast_early: %0d early tlast beats, required 0", n_last); n_err++; end
        if (got_q.size() == 301 && last_q[300] !== 1'b1) begin $display("FAIL cont_tlast_final: got %b required 1", last_q[300]); n_err++; end
`endif
    endtask

    task automatic test_async_reset();
        num_samples = 16'd0; start = 1'b1; m_axis_tready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        aresetn = 1'b0;
        #1;
        n_vec += 4;
        if (m_axis_tvalid !== 1'b0) begin $display("FAIL arst_tvalid: got %b required 0", m_axis_tvalid); n_err++; end
        if (busy !== 1'b0) begin $display("FAIL arst_busy: got %b required 0", busy); n_err++; end
        if (done !== 1'b0) begin $display("FAIL arst_done: got %b required 0", done); n_err++; end
        if (m_axis_tdata !== 32'h1) begin $display("FAIL arst_tdata: got %h required 00000001", m_axis_tdata); n_err++; end
        tick();
        aresetn = 1'b1;
        tick();
        n_vec++;
        if (m_axis_tdata !== 32'h1) begin $display("FAIL arst_release_tdata: got %h required 00000001", m_axis_tdata); n_err++; end
        num_samples = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        clear_capture();
        capture(8, 1'b0);
        n_vec += 2;
        if (got_q.size() != 4) begin $display("FAIL replay_beats: got %0d required 4", got_q.size()); n_err++; end
        if (done_cnt != 1) begin $display("FAIL replay_done: got %0d required 1", done_cnt); n_err++; end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== SEQ1[i]) begin $display("FAIL replay_tdata[%0d]: got %h required %h", i, got_q[i], SEQ1[i]); n_err++; end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_seed();
        test_load_and_start();
        test_continuous_stop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
